// File: rtl/imm_pkg.sv
// Shared types for the immediate generator: format encoding, opcodes and parameter checks.
package imm_pkg;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_U = 3'b011,
      IMM_J = 3'b100
   } imm_fmt_e;

   localparam logic [2:0] IMM_ILLEGAL = 3'b111;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   function automatic logic legal_xlen(input int xlen);
      return (xlen == 32) || (xlen == 64);
   endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Beat-level bus of the immediate generator: input beat, output beat and pipeline flush.
interface imm_gen_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      In;
   logic [2:0]       ImmSrc;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  Imm_Ext;
   logic             out_illegal;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output flush, in_valid, In, ImmSrc, in_tag, out_ready,
      input  in_ready, out_valid, Imm_Ext, out_illegal, out_tag
   );

   modport slave (
      input  flush, in_valid, In, ImmSrc, in_tag, out_ready,
      output in_ready, out_valid, Imm_Ext, out_illegal, out_tag
   );
endinterface

// File: rtl/imm_format.sv
// Combinational RISC-V immediate extraction for the I/S/B/U/J formats, sign-extended to XLEN.
// Unknown format codes yield a zero immediate and raise illegal.
module imm_format
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     In,
   input  logic [2:0]      fmt,
   output logic [XLEN-1:0] imm,
   output logic            illegal
);

   logic [31:0] imm32;
   logic        unused_opcode;

   assign unused_opcode = ^In[6:0];

   always_comb begin
      imm32   = '0;
      illegal = 1'b0;
      case (fmt)
         IMM_I:   imm32 = {{20{In[31]}}, In[31:20]};
         IMM_S:   imm32 = {{20{In[31]}}, In[31:25], In[11:7]};
         IMM_B:   imm32 = {{19{In[31]}}, In[31], In[7], In[30:25], In[11:8], 1'b0};
         IMM_U:   imm32 = {In[31:12], 12'h000};
         IMM_J:   imm32 = {{11{In[31]}}, In[31], In[19:12], In[20], In[30:21], 1'b0};
         default: illegal = 1'b1;
      endcase
   end

   // Every format already carries In[31] as its top bit, so widening is a plain sign extension.
   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: format decode + extraction, then STAGES valid-tagged registers.
// Ready chains combinationally back from out_ready; flush and rst empty the pipe on the next edge.
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int STAGES      = 1,
   parameter int TAG_W       = 32,
   parameter int AUTO_DECODE = 0
) (
   input logic           clk,
   input logic           rst,
   imm_gen_pipe_if.slave bus
);

   if (!legal_xlen(XLEN) || (STAGES < 1) || (STAGES > 3)) begin : g_param_err
      $error("imm_gen_pipe: unsupported XLEN=%0d or STAGES=%0d", XLEN, STAGES);
   end

   logic [2:0]      fmt_d;
   logic [XLEN-1:0] fmt_imm_d;
   logic            fmt_ill_d;

   always_comb begin
      fmt_d = bus.ImmSrc;
      if (AUTO_DECODE != 0) begin
         case (bus.In[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: fmt_d = IMM_I;
            OPC_STORE:                                  fmt_d = IMM_S;
            OPC_BRANCH:                                 fmt_d = IMM_B;
            OPC_LUI, OPC_AUIPC:                         fmt_d = IMM_U;
            OPC_JAL:                                    fmt_d = IMM_J;
            default:                                    fmt_d = IMM_ILLEGAL;
         endcase
      end
   end

   imm_format #(.XLEN(XLEN)) u_format (
      .In      (bus.In),
      .fmt     (fmt_d),
      .imm     (fmt_imm_d),
      .illegal (fmt_ill_d)
   );

   logic [STAGES-1:0] st_vld;
   logic [STAGES-1:0] st_rdy;
   logic [XLEN-1:0]   st_imm [STAGES];
   logic              st_ill [STAGES];
   logic [TAG_W-1:0]  st_tag [STAGES];

   // A stage can take a beat when it is empty or its own beat moves on this cycle.
   always_comb begin : ready_chain
      logic rdy;
      rdy    = bus.out_ready;
      st_rdy = '0;
      for (int s = STAGES - 1; s >= 0; s--) begin
         rdy       = !st_vld[s] || rdy;
         st_rdy[s] = rdy;
      end
   end

   genvar s;
   for (s = 0; s < STAGES; s++) begin : g_stage
      logic             up_vld_d;
      logic [XLEN-1:0]  up_imm_d;
      logic             up_ill_d;
      logic [TAG_W-1:0] up_tag_d;
      logic             vld_q;
      logic [XLEN-1:0]  imm_q;
      logic             ill_q;
      logic [TAG_W-1:0] tag_q;

      if (s == 0) begin : g_head
         assign up_vld_d = bus.in_valid;
         assign up_imm_d = fmt_imm_d;
         assign up_ill_d = fmt_ill_d;
         assign up_tag_d = bus.in_tag;
      end else begin : g_body
         assign up_vld_d = st_vld[s-1];
         assign up_imm_d = st_imm[s-1];
         assign up_ill_d = st_ill[s-1];
         assign up_tag_d = st_tag[s-1];
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q <= 1'b0;
            imm_q <= '0;
            ill_q <= 1'b0;
            tag_q <= '0;
         end else begin
            if (bus.flush) begin
               vld_q <= 1'b0;
            end else if (st_rdy[s]) begin
               vld_q <= up_vld_d;
            end
            // Payload only moves with a real beat to keep idle toggling down.
            if (!bus.flush && st_rdy[s] && up_vld_d) begin
               imm_q <= up_imm_d;
               ill_q <= up_ill_d;
               tag_q <= up_tag_d;
            end
         end
      end

      assign st_vld[s] = vld_q;
      assign st_imm[s] = imm_q;
      assign st_ill[s] = ill_q;
      assign st_tag[s] = tag_q;
   end

   assign bus.in_ready    = st_rdy[0];
   assign bus.out_valid   = st_vld[STAGES-1];
   assign bus.Imm_Ext     = st_imm[STAGES-1];
   assign bus.out_illegal = st_ill[STAGES-1];
   assign bus.out_tag     = st_tag[STAGES-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit single-stage manual-format instance and a 64-bit
// three-stage auto-decode instance, checked against an arithmetic immediate model.
module tb_imm_gen_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) ifa ();
   imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) ifb ();

   imm_gen_pipe #(.XLEN(32), .STAGES(1), .TAG_W(32), .AUTO_DECODE(0)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   imm_gen_pipe #(.XLEN(64), .STAGES(3), .TAG_W(32), .AUTO_DECODE(1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   typedef struct {
      logic [31:0] ins;
      logic [2:0]  src;
      logic [31:0] tag;
      int          cyc;
   } acc_t;

   typedef struct {
      logic [63:0] imm;
      logic        ill;
      logic [31:0] tag;
      int          cyc;
   } obs_t;

   acc_t acc_a[$], acc_b[$];
   obs_t obs_a[$], obs_b[$];
   int   checks = 0, errors = 0, cyc = 0;
   bit   fire_a, fire_b, held_b;
   obs_t held_v;
   int   hold_bad = 0, full_seen = 0, full_bad = 0;

   // Immediate value from the ISA field layout, built as an integer and wrapped to two's complement.
   function automatic void ref_imm(input logic [31:0] ins, input logic [2:0] src, input bit auto_dec,
                                   input int xlen, output logic [63:0] imm, output logic ill);
      longint u, v, one;
      int f, w;
      one = 1;
      u = longint'(ins);
      f = int'(src);
      if (auto_dec) begin
         case (u % 128)
            3, 19, 103, 115: f = 0;
            35:              f = 1;
            99:              f = 2;
            55, 23:          f = 3;
            111:             f = 4;
            default:         f = 7;
         endcase
      end
      ill = 1'b0;
      v = 0;
      w = 32;
      case (f)
         0: begin v = u / (one << 20); w = 12; end
         1: begin v = (u / (one << 25)) * 32 + (u / 128) % 32; w = 12; end
         2: begin
            v = (u / (one << 31)) * 4096 + ((u / 128) % 2) * 2048
              + ((u / (one << 25)) % 64) * 32 + ((u / 256) % 16) * 2;
            w = 13;
         end
         3: begin v = u - (u % 4096); w = 32; end
         4: begin
            v = (u / (one << 31)) * (one << 20) + ((u / 4096) % 256) * 4096
              + ((u / (one << 20)) % 2) * 2048 + ((u / (one << 21)) % 1024) * 2;
            w = 21;
         end
         default: ill = 1'b1;
      endcase
      if (v >= (one << (w - 1))) v = v - (one << w);
      imm = 64'(v);
      if (xlen == 32) imm[63:32] = '0;
   endfunction

   // One clock cycle: sample handshakes just after the falling edge, then wait for the next one.
   task automatic step();
      acc_t a;
      obs_t o;
      #1;
      fire_a = 1'b0;
      fire_b = 1'b0;
      if (ifa.out_valid && ifa.out_ready && !rst) begin
         o.imm = {32'h0, ifa.Imm_Ext}; o.ill = ifa.out_illegal; o.tag = ifa.out_tag; o.cyc = cyc;
         obs_a.push_back(o);
      end
      if (rst || ifa.flush) begin
         while (acc_a.size() > obs_a.size()) void'(acc_a.pop_back());
      end else if (ifa.in_valid && ifa.in_ready) begin
         a.ins = ifa.In; a.src = ifa.ImmSrc; a.tag = ifa.in_tag; a.cyc = cyc;
         acc_a.push_back(a);
         fire_a = 1'b1;
      end
      if (held_b) begin
         if (!ifb.out_valid || ifb.Imm_Ext !== held_v.imm || ifb.out_illegal !== held_v.ill ||
             ifb.out_tag !== held_v.tag) hold_bad++;
      end
      held_b = ifb.out_valid && !ifb.out_ready && !rst && !ifb.flush;
      held_v.imm = ifb.Imm_Ext; held_v.ill = ifb.out_illegal; held_v.tag = ifb.out_tag;
      if (!rst && !ifb.flush && (acc_b.size() - obs_b.size()) == 3 && !ifb.out_ready) begin
         full_seen++;
         if (ifb.in_ready) full_bad++;
      end
      if (ifb.out_valid && ifb.out_ready && !rst) begin
         o.imm = ifb.Imm_Ext; o.ill = ifb.out_illegal; o.tag = ifb.out_tag; o.cyc = cyc;
         obs_b.push_back(o);
      end
      if (rst || ifb.flush) begin
         while (acc_b.size() > obs_b.size()) void'(acc_b.pop_back());
      end else if (ifb.in_valid && ifb.in_ready) begin
         a.ins = ifb.In; a.src = ifb.ImmSrc; a.tag = ifb.in_tag; a.cyc = cyc;
         acc_b.push_back(a);
         fire_b = 1'b1;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic clear_q();
      acc_a.delete(); obs_a.delete(); acc_b.delete(); obs_b.delete();
   endtask

   task automatic drive_a(input logic [31:0] ins, input logic [2:0] src, input logic [31:0] tag);
      ifa.in_valid = 1'b1; ifa.In = ins; ifa.ImmSrc = src; ifa.in_tag = tag;
      for (int i = 0; i < 20; i++) begin
         step();
         if (fire_a) break;
      end
      checks++;
      if (!fire_a) begin
         errors++;
         $display("FAIL drive_a_accept: tag %0d accepted=0, required 1 within 20 cycles", tag);
      end
      ifa.in_valid = 1'b0;
   endtask

   task automatic drive_b(input logic [31:0] ins, input logic [2:0] src, input logic [31:0] tag);
      ifb.in_valid = 1'b1; ifb.In = ins; ifb.ImmSrc = src; ifb.in_tag = tag;
      for (int i = 0; i < 20; i++) begin
         step();
         if (fire_b) break;
      end
      checks++;
      if (!fire_b) begin
         errors++;
         $display("FAIL drive_b_accept: tag %0d accepted=0, required 1 within 20 cycles", tag);
      end
      ifb.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
      checks += 10;
      if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL reset_a_in_ready: got %b, expected 1", ifa.in_ready); end
      if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_out_valid: got %b, expected 0", ifa.out_valid); end
      if (ifa.Imm_Ext !== 32'h0) begin errors++; $display("FAIL reset_a_imm: got %h, expected 0", ifa.Imm_Ext); end
      if (ifa.out_illegal !== 1'b0) begin errors++; $display("FAIL reset_a_illegal: got %b, expected 0", ifa.out_illegal); end
      if (ifa.out_tag !== 32'h0) begin errors++; $display("FAIL reset_a_tag: got %h, expected 0", ifa.out_tag); end
      if (ifb.in_ready !== 1'b1) begin errors++; $display("FAIL reset_b_in_ready: got %b, expected 1", ifb.in_ready); end
      if (ifb.out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_out_valid: got %b, expected 0", ifb.out_valid); end
      if (ifb.Imm_Ext !== 64'h0) begin errors++; $display("FAIL reset_b_imm: got %h, expected 0", ifb.Imm_Ext); end
      if (ifb.out_illegal !== 1'b0) begin errors++; $display("FAIL reset_b_illegal: got %b, expected 0", ifb.out_illegal); end
      if (ifb.out_tag !== 32'h0) begin errors++; $display("FAIL reset_b_tag: got %h, expected 0", ifb.out_tag); end
      clear_q();
   endtask

   task automatic test_is_stream();
      clear_q();
      ifa.out_ready = 1'b1;
      drive_a(32'hFFF00093, 3'b000, 32'd1);
      drive_a(32'hFE112E23, 3'b001, 32'd2);
      repeat (3) step();
      checks++;
      if (obs_a.size() != 2 || acc_a.size() != 2) begin
         errors++;
         $display("FAIL is_count: got %0d outputs, expected 2", obs_a.size());
      end else begin
         checks += 5;
         if (obs_a[0].imm !== 64'hFFFFFFFF) begin errors++; $display("FAIL i_imm: got %h, expected ffffffff", obs_a[0].imm); end
         if (obs_a[1].imm !== 64'hFFFFFFFC) begin errors++; $display("FAIL s_imm: got %h, expected fffffffc", obs_a[1].imm); end
         if (obs_a[0].cyc - acc_a[0].cyc != 1) begin errors++; $display("FAIL is_latency0: got %0d, expected 1", obs_a[0].cyc - acc_a[0].cyc); end
         if (obs_a[1].cyc - acc_a[1].cyc != 1) begin errors++; $display("FAIL is_latency1: got %0d, expected 1", obs_a[1].cyc - acc_a[1].cyc); end
         if (obs_a[1].cyc - obs_a[0].cyc != 1) begin errors++; $display("FAIL is_throughput: gap %0d, expected 1", obs_a[1].cyc - obs_a[0].cyc); end
      end
   endtask

   task automatic test_illegal_src();
      logic [2:0] srcs [3];
      srcs = '{3'b111, 3'b101, 3'b110};
      clear_q();
      foreach (srcs[i]) drive_a($urandom | 32'h8000_0000, srcs[i], 32'd50 + i);
      repeat (3) step();
      checks++;
      if (obs_a.size() != 3) begin
         errors++;
         $display("FAIL illegal_count: got %0d outputs, expected 3", obs_a.size());
      end else begin
         foreach (obs_a[i]) begin
            checks++;
            if (obs_a[i].imm !== 64'h0 || obs_a[i].ill !== 1'b1 || obs_a[i].tag !== 32'd50 + i) begin
               errors++;
               $display("FAIL illegal_src%0d: got imm=%h ill=%b tag=%0d, expected imm=0 ill=1 tag=%0d",
                        i, obs_a[i].imm, obs_a[i].ill, obs_a[i].tag, 50 + i);
            end
         end
      end
   endtask

   task automatic test_auto_decode();
      logic [31:0] vin [4];
      logic [63:0] vimm [4];
      logic        vill [4];
      vin  = '{32'hABCDE2B7, 32'h0010006F, 32'hFE000CE3, 32'h00000033};
      vimm = '{64'hFFFFFFFFABCDE000, 64'h0000000000000800, 64'hFFFFFFFFFFFFFFF8, 64'h0};
      vill = '{1'b0, 1'b0, 1'b0, 1'b1};
      clear_q();
      ifb.out_ready = 1'b1;
      foreach (vin[i]) drive_b(vin[i], 3'($urandom_range(0, 7)), 32'd100 + i);
      repeat (5) step();
      checks++;
      if (obs_b.size() != 4) begin
         errors++;
         $display("FAIL auto_count: got %0d outputs, expected 4", obs_b.size());
      end else begin
         foreach (vin[i]) begin
            checks++;
            if (obs_b[i].imm !== vimm[i] || obs_b[i].ill !== vill[i] || obs_b[i].tag !== 32'd100 + i ||
                obs_b[i].cyc - acc_b[i].cyc != 3) begin
               errors++;
               $display("FAIL auto_vec%0d: got imm=%h ill=%b tag=%0d lat=%0d, expected imm=%h ill=%b tag=%0d lat=3",
                        i, obs_b[i].imm, obs_b[i].ill, obs_b[i].tag, obs_b[i].cyc - acc_b[i].cyc,
                        vimm[i], vill[i], 100 + i);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [6:0]  opcs [10];
      logic [31:0] r;
      logic [63:0] e;
      logic        ei;
      opcs = '{7'd3, 7'd19, 7'd103, 7'd115, 7'd35, 7'd99, 7'd55, 7'd23, 7'd111, 7'd51};
      clear_q();
      hold_bad = 0;
      ifa.in_valid = 1'b0;
      ifb.in_valid = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (!ifa.in_valid || fire_a) begin
            ifa.in_valid = ($urandom_range(0, 3) != 0);
            ifa.In = $urandom;
            ifa.ImmSrc = 3'($urandom_range(0, 7));
            ifa.in_tag = $urandom;
         end
         if (!ifb.in_valid || fire_b) begin
            r = $urandom;
            ifb.in_valid = ($urandom_range(0, 3) != 0);
            ifb.In = {r[31:7], opcs[$urandom_range(0, 9)]};
            ifb.ImmSrc = 3'($urandom_range(0, 7));
            ifb.in_tag = $urandom;
         end
         ifa.out_ready = ($urandom_range(0, 3) != 0);
         ifb.out_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
      ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
      repeat (8) step();
      checks += 2;
      if (obs_a.size() != acc_a.size() || obs_a.size() < 100) begin
         errors++; $display("FAIL rand_a_count: got %0d outputs, expected %0d", obs_a.size(), acc_a.size());
      end
      if (obs_b.size() != acc_b.size() || obs_b.size() < 100) begin
         errors++; $display("FAIL rand_b_count: got %0d outputs, expected %0d", obs_b.size(), acc_b.size());
      end
      for (int i = 0; i < obs_a.size() && i < acc_a.size(); i++) begin
         ref_imm(acc_a[i].ins, acc_a[i].src, 1'b0, 32, e, ei);
         checks++;
         if (obs_a[i].imm !== e || obs_a[i].ill !== ei || obs_a[i].tag !== acc_a[i].tag) begin
            errors++;
            $display("FAIL rand_a[%0d]: in=%h src=%0d got imm=%h ill=%b tag=%h, expected imm=%h ill=%b tag=%h",
                     i, acc_a[i].ins, acc_a[i].src, obs_a[i].imm, obs_a[i].ill, obs_a[i].tag, e, ei, acc_a[i].tag);
         end
      end
      for (int i = 0; i < obs_b.size() && i < acc_b.size(); i++) begin
         ref_imm(acc_b[i].ins, acc_b[i].src, 1'b1, 64, e, ei);
         checks++;
         if (obs_b[i].imm !== e || obs_b[i].ill !== ei || obs_b[i].tag !== acc_b[i].tag) begin
            errors++;
            $display("FAIL rand_b[%0d]: in=%h got imm=%h ill=%b tag=%h, expected imm=%h ill=%b tag=%h",
                     i, acc_b[i].ins, obs_b[i].imm, obs_b[i].ill, obs_b[i].tag, e, ei, acc_b[i].tag);
         end
      end
   endtask

   task automatic test_backpressure();
      int nxt;
      logic [63:0] e;
      logic        ei;
      clear_q();
      full_seen = 0;
      full_bad = 0;
      nxt = 0;
      for (int k = 0; k < 60 && obs_b.size() < 8; k++) begin
         ifb.out_ready = !(k >= 4 && k < 8);
         ifb.in_valid = (nxt < 8);
         ifb.In = 32'h0000_0013 | (32'(nxt) << 20);
         ifb.ImmSrc = 3'b000;
         ifb.in_tag = 32'(nxt);
         step();
         if (fire_b) nxt++;
      end
      ifb.in_valid = 1'b0;
      ifb.out_ready = 1'b1;
      checks += 3;
      if (full_seen == 0 || full_bad != 0) begin
         errors++;
         $display("FAIL bp_in_ready: in_ready high in %0d of %0d full stalled cycles, expected 0 (and >0 cycles)",
                  full_bad, full_seen);
      end
      if (hold_bad != 0) begin
         errors++; $display("FAIL bp_output_hold: %0d unstable stalled cycles, expected 0", hold_bad);
      end
      if (obs_b.size() != 8) begin
         errors++; $display("FAIL bp_count: got %0d outputs, expected 8", obs_b.size());
      end
      for (int i = 0; i < obs_b.size() && i < 8; i++) begin
         ref_imm(32'h0000_0013 | (32'(i) << 20), 3'b000, 1'b1, 64, e, ei);
         checks++;
         if (obs_b[i].tag !== 32'(i) || obs_b[i].imm !== e) begin
            errors++;
            $display("FAIL bp_order[%0d]: got tag=%0d imm=%h, expected tag=%0d imm=%h", i, obs_b[i].tag, obs_b[i].imm, i, e);
         end
      end
   endtask

   task automatic test_flush();
      clear_q();
      ifb.out_ready = 1'b0;
      drive_b(32'h00100013, 3'b000, 32'd10);
      drive_b(32'h00200013, 3'b000, 32'd11);
      drive_b(32'h00300013, 3'b000, 32'd12);
      #1;
      checks++;
      if (ifb.in_ready !== 1'b0 || ifb.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL flush_prefill: got in_ready=%b out_valid=%b, expected 0 1", ifb.in_ready, ifb.out_valid);
      end
      ifb.flush = 1'b1; ifb.in_valid = 1'b1; ifb.In = 32'h00400013; ifb.in_tag = 32'd13;
      step();
      ifb.flush = 1'b0; ifb.in_valid = 1'b0;
      checks++;
      if (ifb.out_valid !== 1'b0) begin
         errors++; $display("FAIL flush_out_valid: got %b, expected 0", ifb.out_valid);
      end
      ifb.out_ready = 1'b1;
      clear_q();
      drive_b(32'h00500013, 3'b000, 32'd14);
      repeat (5) step();
      checks++;
      if (obs_b.size() != 1 || acc_b.size() != 1) begin
         errors++; $display("FAIL flush_after_count: got %0d outputs, expected 1", obs_b.size());
      end else begin
         checks++;
         if (obs_b[0].tag !== 32'd14 || obs_b[0].imm !== 64'd5 || obs_b[0].cyc - acc_b[0].cyc != 3) begin
            errors++;
            $display("FAIL flush_after_beat: got tag=%0d imm=%h lat=%0d, expected tag=14 imm=5 lat=3",
                     obs_b[0].tag, obs_b[0].imm, obs_b[0].cyc - acc_b[0].cyc);
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_q();
      ifb.out_ready = 1'b1;
      drive_b(32'hFFF00093, 3'b000, 32'd20);
      drive_b(32'hFFF00093, 3'b000, 32'd21);
      drive_b(32'hFFF00093, 3'b000, 32'd22);
      ifb.in_valid = 1'b1; ifb.in_tag = 32'd23;
      rst = 1'b1;
      step();
      rst = 1'b0;
      ifb.in_valid = 1'b0;
      #1;
      checks += 5;
      if (ifb.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b, expected 0", ifb.out_valid); end
      if (ifb.Imm_Ext !== 64'h0) begin errors++; $display("FAIL rstmid_imm: got %h, expected 0", ifb.Imm_Ext); end
      if (ifb.out_illegal !== 1'b0) begin errors++; $display("FAIL rstmid_illegal: got %b, expected 0", ifb.out_illegal); end
      if (ifb.out_tag !== 32'h0) begin errors++; $display("FAIL rstmid_tag: got %h, expected 0", ifb.out_tag); end
      if (ifb.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b, expected 1", ifb.in_ready); end
      repeat (4) step();
      checks++;
      if (obs_b.size() != 0) begin
         errors++; $display("FAIL rstmid_ghost: got %0d outputs after reset, expected 0", obs_b.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      held_b = 1'b0;
      ifa.flush = 1'b0; ifa.in_valid = 1'b0; ifa.In = '0; ifa.ImmSrc = '0; ifa.in_tag = '0; ifa.out_ready = 1'b1;
      ifb.flush = 1'b0; ifb.in_valid = 1'b0; ifb.In = '0; ifb.ImmSrc = '0; ifb.in_tag = '0; ifb.out_ready = 1'b1;
      test_reset();
      test_is_stream();
      test_illegal_src();
      test_auto_decode();
      test_random();
      test_backpressure();
      test_flush();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
